// File: rtl/raytracer_dda.sv
// -----------------------------------------------------------------------------
// raytracer_dda
//
// Grid raytracer sitting between the column renderer and the grid memory.
// Starting from a fixed-point position, it repeatedly adds a signed per-step
// direction vector. It looks up the map tile under each visited position and
// stops on the first non-empty tile (HIT), on leaving the map (MISS), or when
// the step budget is exhausted (TIMEOUT).
//
// Registered-read grid memories are supported: GRID_LAT cycles are spent in
// WAIT after every address change before grid_out is trusted.
//
// Ports
//   clock       system clock
//   reset       asynchronous, active-low reset
//   start       begin a trace (sampled only while idle)
//   x, y        unsigned fixed-point start position
//   dir_x/y     signed two's-complement increment per step
//   busy        high from LOAD through DONE inclusive
//   done        one-cycle pulse; results are valid from this cycle on
//   status      00 HIT, 01 MISS (left map), 10 TIMEOUT
//   result_x/y  current / final cell coordinates
//   hit_tile    tile code on HIT, otherwise 0
//   step_count  number of steps taken
//   grid_x/y    grid memory address (cell under the current position)
//   grid_out    grid memory read data (0 = empty)
// -----------------------------------------------------------------------------
module raytracer_dda #(
    parameter int X_W        = 14,
    parameter int Y_W        = 13,
    parameter int CELL_SHIFT = 8,
    parameter int DIR_W      = 10,
    parameter int MAP_COLS   = 64,
    parameter int MAP_ROWS   = 32,
    parameter int TILE_W     = 3,
    parameter int GRID_LAT   = 0,
    parameter int STEP_W     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [X_W-1:0]            x,
    input  logic [Y_W-1:0]            y,
    input  logic [DIR_W-1:0]          dir_x,
    input  logic [DIR_W-1:0]          dir_y,
    output logic                      busy,
    output logic                      done,
    output logic [1:0]                status,
    output logic [X_W-CELL_SHIFT-1:0] result_x,
    output logic [Y_W-CELL_SHIFT-1:0] result_y,
    output logic [TILE_W-1:0]         hit_tile,
    output logic [STEP_W-1:0]         step_count,
    output logic [X_W-CELL_SHIFT-1:0] grid_x,
    output logic [Y_W-CELL_SHIFT-1:0] grid_y,
    input  logic [TILE_W-1:0]         grid_out
);

    localparam int CX_W = X_W - CELL_SHIFT;
    localparam int CY_W = Y_W - CELL_SHIFT;

    // Map limits held one bit wider than a cell index so that a limit equal
    // to 2^CX_W (a map filling the whole address space) is representable.
    localparam logic [CX_W:0] COLS_LIM = (CX_W + 1)'(MAP_COLS);
    localparam logic [CY_W:0] ROWS_LIM = (CY_W + 1)'(MAP_ROWS);

    localparam logic [STEP_W-1:0] MAX_STEPS = '1;
    localparam logic [1:0]        LAT_INIT  = 2'(GRID_LAT);
    localparam bit                HAS_LAT   = (GRID_LAT > 0);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] ST_HIT     = 2'b00;
    localparam logic [1:0] ST_MISS    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    logic [2:0]        state;
    logic [X_W-1:0]    pos_x;
    logic [Y_W-1:0]    pos_y;
    logic [DIR_W-1:0]  dir_xr;
    logic [DIR_W-1:0]  dir_yr;
    logic [STEP_W-1:0] steps;
    logic [1:0]        wait_cnt;
    logic [1:0]        status_r;
    logic [TILE_W-1:0] hit_tile_r;

    logic [X_W:0]      next_x;
    logic [Y_W:0]      next_y;
    logic              start_off_map;
    logic              next_off_map;

    // The address and the reported cell both come straight from the
    // position registers, so the result always names the cell last visited.
    assign grid_x     = pos_x[X_W-1:CELL_SHIFT];
    assign grid_y     = pos_y[Y_W-1:CELL_SHIFT];
    assign result_x   = grid_x;
    assign result_y   = grid_y;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign status     = status_r;
    assign hit_tile   = hit_tile_r;
    assign step_count = steps;

    // Candidate next position, one bit wider than the position. Because
    // |dir| never exceeds 2^(DIR_W-1) <= 2^X_W, both an underflow below
    // zero and an overflow past 2^X_W land with the top bit set, so that bit
    // alone flags "left the addressable range".
    assign next_x = {1'b0, pos_x} + {{(X_W + 1 - DIR_W){dir_xr[DIR_W-1]}}, dir_xr};
    assign next_y = {1'b0, pos_y} + {{(Y_W + 1 - DIR_W){dir_yr[DIR_W-1]}}, dir_yr};

    // Start position rejected before any memory lookup if its cell lies
    // outside the valid map area.
    assign start_off_map = ({1'b0, x[X_W-1:CELL_SHIFT]} >= COLS_LIM) ||
                           ({1'b0, y[Y_W-1:CELL_SHIFT]} >= ROWS_LIM);

    assign next_off_map  = next_x[X_W] || next_y[Y_W] ||
                           ({1'b0, next_x[X_W-1:CELL_SHIFT]} >= COLS_LIM) ||
                           ({1'b0, next_y[Y_W-1:CELL_SHIFT]} >= ROWS_LIM);

    // Trace controller. LOAD captures the inputs so they may change freely
    // afterwards. Each visited cell costs one CHECK, preceded by GRID_LAT
    // WAIT cycles so that a registered grid memory has caught up with the
    // new address. Results are cleared only in LOAD, so they hold after DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pos_x      <= '0;
            pos_y      <= '0;
            dir_xr     <= '0;
            dir_yr     <= '0;
            steps      <= '0;
            wait_cnt   <= '0;
            status_r   <= ST_HIT;
            hit_tile_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    pos_x      <= x;
                    pos_y      <= y;
                    dir_xr     <= dir_x;
                    dir_yr     <= dir_y;
                    steps      <= '0;
                    wait_cnt   <= LAT_INIT;
                    status_r   <= ST_HIT;
                    hit_tile_r <= '0;
                    if (start_off_map) begin
                        status_r <= ST_MISS;
                        state    <= S_DONE;
                    end else if (HAS_LAT) begin
                        state <= S_WAIT;
                    end else begin
                        state <= S_CHECK;
                    end
                end

                // The counter is tested before it is decremented, so exactly
                // GRID_LAT cycles are spent here.
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 2'd1;
                    if (wait_cnt == 2'd1) begin
                        state <= S_CHECK;
                    end
                end

                // A solid tile wins over an exhausted budget.
                S_CHECK: begin
                    if (grid_out != '0) begin
                        status_r   <= ST_HIT;
                        hit_tile_r <= grid_out;
                        state      <= S_DONE;
                    end else if (steps == MAX_STEPS) begin
                        status_r <= ST_TIMEOUT;
                        state    <= S_DONE;
                    end else begin
                        state <= S_STEP;
                    end
                end

                // A step that would leave the map is not taken: position and
                // step count stay on the last valid cell.
                S_STEP: begin
                    if (next_off_map) begin
                        status_r <= ST_MISS;
                        state    <= S_DONE;
                    end else begin
                        pos_x    <= next_x[X_W-1:0];
                        pos_y    <= next_y[Y_W-1:0];
                        steps    <= steps + 1'b1;
                        wait_cnt <= LAT_INIT;
                        state    <= HAS_LAT ? S_WAIT : S_CHECK;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
